// File: rtl/cva6_ptw_arb_sv32.sv
// rtl/cva6_ptw_arb_sv32.sv - round-robin ITLB/DTLB arbiter and sequencer for the Sv32 PTW
// Combinational ack/start/done pulses, latched walk context, and flush/drain handling.
module cva6_ptw_arb_sv32 #(
  parameter int VLEN       = 32,
  parameter int ASID_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  input  logic                  itlb_req_i,
  input  logic [VLEN-1:0]       itlb_vaddr_i,
  output logic                  itlb_ack_o,
  output logic                  itlb_done_o,
  output logic                  itlb_err_o,
  input  logic                  dtlb_req_i,
  input  logic [VLEN-1:0]       dtlb_vaddr_i,
  input  logic                  dtlb_is_store_i,
  output logic                  dtlb_ack_o,
  output logic                  dtlb_done_o,
  output logic                  dtlb_err_o,
  output logic                  dtlb_access_err_o,
  output logic                  ptw_start_o,
  output logic [VLEN-1:0]       ptw_vaddr_o,
  output logic                  ptw_itlb_o,
  output logic                  ptw_is_store_o,
  output logic [ASID_WIDTH-1:0] ptw_asid_o,
  input  logic                  ptw_active_i,
  input  logic                  ptw_update_i,
  input  logic                  ptw_error_i,
  input  logic                  ptw_access_err_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WALK  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [VLEN-1:0]       r_vaddr;
  logic [ASID_WIDTH-1:0] r_asid;
  logic                  r_owner_itlb;
  logic                  r_is_store;
  logic                  r_last_itlb;

  logic w_grant;
  logic w_grant_itlb;
  logic w_done;
  logic w_complete;

  assign w_complete = ptw_update_i | ptw_error_i | ptw_access_err_i;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_grant_itlb = 1'b0;
    w_done       = 1'b0;
    ptw_start_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush_i && !rst_i && (itlb_req_i || dtlb_req_i)) begin
          w_grant      = 1'b1;
          // Contention goes to whichever side was not served last.
          w_grant_itlb = itlb_req_i && (!dtlb_req_i || !r_last_itlb);
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else if (!ptw_active_i) begin
          ptw_start_o = 1'b1;
          w_state_nxt = S_WALK;
        end
      end
      S_WALK: begin
        if (flush_i) begin
          w_state_nxt = S_DRAIN;
        end else if (w_complete) begin
          w_done      = 1'b1;
          w_state_nxt = S_DRAIN;
        end else if (!ptw_active_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!ptw_active_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign itlb_ack_o  = w_grant &  w_grant_itlb;
  assign dtlb_ack_o  = w_grant & ~w_grant_itlb;
  assign itlb_done_o = w_done &  r_owner_itlb;
  assign dtlb_done_o = w_done & ~r_owner_itlb;

  // ITLB has no access-fault output, so a PMP fault is reported as a page fault.
  assign itlb_err_o        = itlb_done_o & (ptw_error_i | ptw_access_err_i);
  assign dtlb_access_err_o = dtlb_done_o & ptw_access_err_i;
  assign dtlb_err_o        = dtlb_done_o & ptw_error_i & ~ptw_access_err_i;

  assign ptw_vaddr_o    = r_vaddr;
  assign ptw_itlb_o     = r_owner_itlb;
  assign ptw_is_store_o = r_is_store;
  assign ptw_asid_o     = r_asid;
  assign busy_o         = (r_state != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_vaddr      <= '0;
      r_asid       <= '0;
      r_owner_itlb <= 1'b0;
      r_is_store   <= 1'b0;
      r_last_itlb  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_vaddr      <= w_grant_itlb ? itlb_vaddr_i : dtlb_vaddr_i;
        r_asid       <= asid_i;
        r_owner_itlb <= w_grant_itlb;
        r_is_store   <= w_grant_itlb ? 1'b0 : dtlb_is_store_i;
        r_last_itlb  <= w_grant_itlb;
      end
    end
  end

endmodule

// File: tb/tb_cva6_ptw_arb_sv32.sv
// tb/tb_cva6_ptw_arb_sv32.sv - directed self-checking bench for cva6_ptw_arb_sv32
module tb_cva6_ptw_arb_sv32;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [0:0]  asid;
  logic        itlb_req;
  logic [31:0] itlb_vaddr;
  logic        itlb_ack, itlb_done, itlb_err;
  logic        dtlb_req;
  logic [31:0] dtlb_vaddr;
  logic        dtlb_is_store;
  logic        dtlb_ack, dtlb_done, dtlb_err, dtlb_access_err;
  logic        ptw_start;
  logic [31:0] ptw_vaddr;
  logic        ptw_itlb, ptw_is_store;
  logic [0:0]  ptw_asid;
  logic        ptw_active, ptw_update, ptw_error, ptw_access_err;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cva6_ptw_arb_sv32 #(.VLEN(32), .ASID_WIDTH(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .asid_i(asid),
    .itlb_req_i(itlb_req), .itlb_vaddr_i(itlb_vaddr),
    .itlb_ack_o(itlb_ack), .itlb_done_o(itlb_done), .itlb_err_o(itlb_err),
    .dtlb_req_i(dtlb_req), .dtlb_vaddr_i(dtlb_vaddr), .dtlb_is_store_i(dtlb_is_store),
    .dtlb_ack_o(dtlb_ack), .dtlb_done_o(dtlb_done), .dtlb_err_o(dtlb_err),
    .dtlb_access_err_o(dtlb_access_err),
    .ptw_start_o(ptw_start), .ptw_vaddr_o(ptw_vaddr), .ptw_itlb_o(ptw_itlb),
    .ptw_is_store_o(ptw_is_store), .ptw_asid_o(ptw_asid),
    .ptw_active_i(ptw_active), .ptw_update_i(ptw_update), .ptw_error_i(ptw_error),
    .ptw_access_err_i(ptw_access_err), .busy_o(busy)
  );

  // {itlb_ack, itlb_done, itlb_err, dtlb_ack, dtlb_done, dtlb_err, dtlb_access_err, ptw_start}
  logic [7:0] pulses;
  assign pulses = {itlb_ack, itlb_done, itlb_err, dtlb_ack, dtlb_done, dtlb_err,
                   dtlb_access_err, ptw_start};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    flush = 0; asid = 1'b0;
    itlb_req = 0; itlb_vaddr = '0;
    dtlb_req = 0; dtlb_vaddr = '0; dtlb_is_store = 0;
    ptw_active = 0; ptw_update = 0; ptw_error = 0; ptw_access_err = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    do_reset();
    settle();
    chk("reset_pulses", pulses, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_vaddr", ptw_vaddr, 32'h0);
    chk("reset_flags", {ptw_itlb, ptw_is_store, ptw_asid}, 3'b000);

    // 1: single DTLB store walk
    tick();
    dtlb_req = 1; dtlb_vaddr = 32'h8040_1000; dtlb_is_store = 1; asid = 1'b1;
    settle(); chk("t1_ack", pulses, 8'h10);
    tick(); dtlb_req = 0; asid = 1'b0;
    settle(); chk("t1_start", pulses, 8'h01);
    chk("t1_vaddr", ptw_vaddr, 32'h8040_1000);
    chk("t1_flags", {ptw_itlb, ptw_is_store, ptw_asid}, 3'b011);
    tick(); ptw_active = 1;
    settle(); chk("t1_walk2", pulses, 8'h00);
    tick();
    settle(); chk("t1_walk3", pulses, 8'h00);
    tick(); ptw_update = 1;
    settle(); chk("t1_done", pulses, 8'h08);
    tick(); ptw_update = 0;
    settle(); chk("t1_drain_busy", busy, 1'b1);
    tick(); ptw_active = 0;
    settle(); chk("t1_drain_last", busy, 1'b1);
    tick();
    settle(); chk("t1_idle", busy, 1'b0);

    // 2: both held, four walks alternate starting with DTLB
    do_reset();
    for (int i = 0; i < 4; i++) begin
      logic own_i;
      own_i = (i % 2) == 1;
      itlb_req = 1; dtlb_req = 1; dtlb_is_store = 1;
      itlb_vaddr = 32'h1000_0000 + i; dtlb_vaddr = 32'h2000_0000 + i;
      settle(); chk($sformatf("t2_ack%0d", i), pulses, own_i ? 8'h80 : 8'h10);
      tick();
      settle(); chk($sformatf("t2_start%0d", i), pulses, 8'h01);
      chk($sformatf("t2_vaddr%0d", i), ptw_vaddr,
          own_i ? 32'h1000_0000 + i : 32'h2000_0000 + i);
      chk($sformatf("t2_flags%0d", i), {ptw_itlb, ptw_is_store}, own_i ? 2'b10 : 2'b01);
      tick(); ptw_active = 1; ptw_update = 1;
      settle(); chk($sformatf("t2_done%0d", i), pulses, own_i ? 8'h40 : 8'h08);
      tick(); ptw_active = 0; ptw_update = 0;
      settle(); chk($sformatf("t2_drain%0d", i), pulses, 8'h00);
      tick();
    end
    itlb_req = 0; dtlb_req = 0;

    // 3: ITLB page fault, next grant waits for PTW idle
    settle(); chk("t3_idle", busy, 1'b0);
    itlb_req = 1; itlb_vaddr = 32'h0000_4000;
    settle(); chk("t3_ack", pulses, 8'h80);
    tick(); itlb_req = 0;
    settle(); chk("t3_start", pulses, 8'h01);
    tick(); ptw_active = 1; ptw_error = 1;
    settle(); chk("t3_done_err", pulses, 8'h60);
    tick(); ptw_error = 0; dtlb_req = 1; dtlb_vaddr = 32'h0000_5000; dtlb_is_store = 0;
    settle(); chk("t3_drain_hold", pulses, 8'h00);
    tick();
    settle(); chk("t3_drain_hold2", pulses, 8'h00);
    tick(); ptw_active = 0;
    settle(); chk("t3_drain_exit", pulses, 8'h00);
    tick();
    settle(); chk("t3_regrant", pulses, 8'h10);

    // 4: DTLB access fault beats page fault
    tick(); dtlb_req = 0;
    settle(); chk("t4_start", pulses, 8'h01);
    tick(); ptw_active = 1; ptw_access_err = 1; ptw_error = 1;
    settle(); chk("t4_done_access", pulses, 8'h0A);
    tick(); ptw_access_err = 0; ptw_error = 0; ptw_active = 0;
    tick();

    // flush in IDLE suppresses ack; flush in ISSUE drops the walk
    dtlb_req = 1; flush = 1;
    settle(); chk("flush_idle_noack", pulses, 8'h00);
    tick(); flush = 0;
    settle(); chk("flush_idle_noidle", busy, 1'b0);
    chk("post_flush_ack", pulses, 8'h10);
    tick(); dtlb_req = 0; flush = 1;
    settle(); chk("flush_issue_nostart", pulses, 8'h00);
    tick(); flush = 0;
    settle(); chk("flush_issue_idle", busy, 1'b0);

    // 5: flush with update in WALK
    dtlb_req = 1; dtlb_vaddr = 32'h0000_6000;
    settle(); chk("t5_ack", pulses, 8'h10);
    tick(); dtlb_req = 0;
    settle(); chk("t5_start", pulses, 8'h01);
    tick(); ptw_active = 1; flush = 1; ptw_update = 1;
    settle(); chk("t5_flush_nodone", pulses, 8'h00);
    tick(); flush = 0;
    settle(); chk("t5_drain_ignore", pulses, 8'h00);
    chk("t5_drain_busy", busy, 1'b1);
    tick(); ptw_update = 0; ptw_active = 0;
    tick();
    settle(); chk("t5_idle", busy, 1'b0);

    // 6: grant while PTW still active
    ptw_active = 1; itlb_req = 1; itlb_vaddr = 32'h0000_7000;
    settle(); chk("t6_ack", pulses, 8'h80);
    tick(); itlb_req = 0;
    settle(); chk("t6_hold1", pulses, 8'h00);
    chk("t6_busy", busy, 1'b1);
    tick();
    settle(); chk("t6_hold2", pulses, 8'h00);
    tick(); ptw_active = 0;
    settle(); chk("t6_start", pulses, 8'h01);
    tick(); ptw_active = 1;
    tick(); ptw_active = 0;
    settle(); chk("t6_abort_nodone", pulses, 8'h00);
    tick();
    settle(); chk("t6_idle", busy, 1'b0);

    // 7: reset mid-walk
    dtlb_req = 1; dtlb_vaddr = 32'h0000_8000; dtlb_is_store = 1;
    tick(); dtlb_req = 0;
    tick(); ptw_active = 1;
    settle(); chk("t7_walk_busy", busy, 1'b1);
    rst = 1; ptw_update = 1;
    settle(); chk("t7_rst_pulses", pulses, 8'h00);
    chk("t7_rst_busy", busy, 1'b0);
    chk("t7_rst_vaddr", ptw_vaddr, 32'h0);
    chk("t7_rst_flags", {ptw_itlb, ptw_is_store, ptw_asid}, 3'b000);
    tick(); rst = 0;
    settle(); chk("t7_post_nodone", pulses, 8'h00);
    tick();
    settle(); chk("t7_post_idle", {busy, pulses}, 9'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cva6_ptw_arb_sv32.md
Name: cva6_ptw_arb_sv32

Overview:
- Sequencer and arbiter in front of the Sv32 hardware page-table walker.
- Accepts walk requests from the ITLB and DTLB miss paths and grants the single PTW to one requester at a time, round-robin.
- Issues exactly one start pulse per granted walk, tracks the walk to completion, and returns success or fault to the owning requester only.
- Handles flushes and never issues a walk while the PTW is still busy with a previous one.

Parameters:
VLEN, 32, virtual address width
ASID_WIDTH, 1, ASID width forwarded to the PTW

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
flush_i  in  1  abandon current and pending walks
asid_i  in  ASID_WIDTH  current ASID, sampled at grant
itlb_req_i  in  1  ITLB miss request (level, held until ack)
itlb_vaddr_i  in  VLEN  ITLB miss address
itlb_ack_o  out  1  one-cycle pulse: ITLB request accepted
itlb_done_o  out  1  one-cycle pulse: ITLB walk finished
itlb_err_o  out  1  page fault, valid with itlb_done_o
dtlb_req_i  in  1  DTLB miss request (level, held until ack)
dtlb_vaddr_i  in  VLEN  DTLB miss address
dtlb_is_store_i  in  1  DTLB miss is a store
dtlb_ack_o  out  1  one-cycle pulse: DTLB request accepted
dtlb_done_o  out  1  one-cycle pulse: DTLB walk finished
dtlb_err_o  out  1  page fault, valid with dtlb_done_o
dtlb_access_err_o  out  1  PMP access fault, valid with dtlb_done_o
ptw_start_o  out  1  one-cycle walk start (PTW shared_tlb_access/miss)
ptw_vaddr_o  out  VLEN  latched walk address
ptw_itlb_o  out  1  walk is for ITLB
ptw_is_store_o  out  1  walk is for a store
ptw_asid_o  out  ASID_WIDTH  latched ASID
ptw_active_i  in  1  PTW not idle
ptw_update_i  in  1  PTW TLB update valid (success)
ptw_error_i  in  1  PTW page fault
ptw_access_err_i  in  1  PTW PMP access fault
busy_o  out  1  state != IDLE

Behaviour:

States: IDLE, ISSUE, WALK, DRAIN.

Reset values:
- State: IDLE.
- All outputs: 0.
- Latched vaddr, asid, owner, and is_store: 0.
- RR pointer favours DTLB first.

IDLE:
- If one or both of itlb_req_i / dtlb_req_i are high, grant one requester:
  - Only one requesting: grant it.
  - Both requesting: grant the one not granted last.
- On grant:
  - Pulse the winner's ack_o in that cycle.
  - Latch vaddr, asid_i, and is_store (is_store forced 0 for ITLB).
  - Set owner; update the RR pointer.
  - Next state: ISSUE.

ISSUE:
- If ptw_active_i=0: assert ptw_start_o for exactly this cycle, then go to WALK.
- Otherwise hold in ISSUE with ptw_start_o=0.

ptw_vaddr_o / ptw_itlb_o / ptw_is_store_o / ptw_asid_o:
- Driven from the latches continuously from the cycle after grant until the next grant.

WALK:
- Wait for the first of ptw_update_i, ptw_error_i, ptw_access_err_i.
- In that cycle, pulse the owner's done_o with:
  - err_o = ptw_error_i
  - access_err_o = ptw_access_err_i (DTLB only)
- Priority if several are high: access_err > error > update.
- ITLB owner with ptw_access_err_i: itlb_err_o=1.
- Next state after done: DRAIN.
- If ptw_active_i falls with no completion signal: go to IDLE, no done pulse.

DRAIN:
- Stay while ptw_active_i=1; go to IDLE when it is 0.
- Completion signals are ignored here.

flush_i (highest priority, same cycle):
- No ack, start, or done pulse is generated in that cycle.
- IDLE or ISSUE: next state IDLE. An already-acked request is dropped and the requester must re-request.
- WALK or DRAIN: next state DRAIN.
- Flush coinciding with a completion: done is suppressed.

Other rules:
- A requester dropping req_i before ack: no effect.
- req_i held high after ack: treated as a new request on the next IDLE.
- At most one walk outstanding; ack-to-start latency is ≥1 cycle (exactly 1 when the PTW is idle).
- rst_i asserted mid-walk returns everything to reset values immediately. No done pulse follows after release.

Test Plan:
1. Only dtlb_req_i, vaddr 0x8040_1000, is_store=1, PTW idle:
   - dtlb_ack_o at cycle 0 and ptw_start_o at cycle 1 with ptw_vaddr_o=0x8040_1000, ptw_is_store_o=1, ptw_itlb_o=0.
   - ptw_update_i at cycle 4 → dtlb_done_o=1, dtlb_err_o=0 at cycle 4.
   - Back to IDLE after ptw_active_i=0.
2. itlb_req_i and dtlb_req_i both held for 4 back-to-back walks:
   - Grants alternate DTLB, ITLB, DTLB, ITLB.
   - Each done pulse goes only to its owner.
3. ITLB walk, ptw_error_i in WALK → itlb_done_o=1 and itlb_err_o=1 for one cycle. Next grant waits until ptw_active_i=0.
4. DTLB walk with ptw_access_err_i=1 and ptw_error_i=1 in the same cycle → dtlb_access_err_o=1, dtlb_err_o=0.
5. flush_i during WALK, with ptw_update_i in the same cycle → no done pulse, state DRAIN. Then IDLE once ptw_active_i=0.
6. Grant while ptw_active_i=1 (PTW in its latency state) → stays in ISSUE with ptw_start_o=0. ptw_start_o pulses in the first cycle ptw_active_i=0.
7. rst_i asserted in WALK → all outputs 0 the same cycle. No done pulse after release.
